// File: rtl/mist_audio_pkg.sv
// Shared constants for the MiST sigma-delta audio output stage.
package mist_audio_pkg;

  localparam int DW_DEF           = 16;
  localparam int INTERP_SHIFT_DEF = 5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci register land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int clamp_lim(input int dw);
    return 1 << (dw - 5);
  endfunction

endpackage

// File: rtl/mist_sd2_channel.sv
// One audio channel: linear interpolator, offset-binary conversion, clamp and
// dithered 2nd-order sigma-delta modulator.
module mist_sd2_channel
  import mist_audio_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int INTERP_SHIFT = INTERP_SHIFT_DEF,
  parameter bit SIGNED_IN    = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accept,
  input  logic          ramp_active,
  input  logic          ramp_last,
  input  logic [DW-1:0] sample,
  input  logic          mute,
  input  logic          dither,
  output logic          pdm,
  output logic          clip,
  output logic [DW-1:0] cur
);

  localparam int IW = DW + 4;
  localparam int SW = DW + 5;
  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] LO  = DW'(clamp_lim(DW));
  localparam logic [DW-1:0] HI  = ~LO;
  localparam logic signed [SW-1:0] SAT_P   = SW'(64'sd1 <<< (DW + 2));
  localparam logic signed [SW-1:0] SAT_N   = -SAT_P;
  localparam logic signed [SW-1:0] FB_FULL = SW'((64'sd1 <<< DW) - 64'sd1);

  function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_P) return IW'(SAT_P);
    if (v < SAT_N) return IW'(SAT_N);
    return IW'(v);
  endfunction

  logic [DW-1:0]        cur_q, cur_d, target_q, target_d, step_q, step_d;
  logic signed [IW-1:0] int1_q, int1_d, int2_q, int2_d;
  logic                 pdm_q, pdm_d, clip_q, clip_d;
  logic signed [DW:0]   diff, step_new;
  logic [DW-1:0]        x_raw, x;
  logic signed [SW-1:0] fb, sum1, sum2;

  always_comb begin
    diff = SIGNED_IN ? ($signed({sample[DW-1], sample}) - $signed({cur_q[DW-1], cur_q}))
                     : ($signed({1'b0, sample}) - $signed({1'b0, cur_q}));
    step_new = diff >>> INTERP_SHIFT;

    cur_d    = cur_q;
    target_d = target_q;
    step_d   = step_q;
    // The accept cycle already takes the first step; the last step snaps to target.
    if (accept) begin
      target_d = sample;
      step_d   = DW'(step_new);
      cur_d    = cur_q + DW'(step_new);
    end else if (ramp_last) begin
      cur_d = target_q;
    end else if (ramp_active) begin
      cur_d = cur_q + step_q;
    end

    x_raw  = mute ? MID : (SIGNED_IN ? (cur_q ^ MID) : cur_q);
    clip_d = (x_raw < LO) || (x_raw > HI);
    x      = (x_raw < LO) ? LO : ((x_raw > HI) ? HI : x_raw);

    fb     = pdm_q ? FB_FULL : '0;
    sum1   = $signed({int1_q[IW-1], int1_q}) + $signed({{(SW-DW){1'b0}}, x}) - fb
           + $signed({{(SW-1){1'b0}}, dither});
    int1_d = sat(sum1);
    sum2   = $signed({int2_q[IW-1], int2_q}) + $signed({int1_d[IW-1], int1_d}) - fb;
    int2_d = sat(sum2);
    pdm_d  = ~int2_d[IW-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q    <= '0;
      target_q <= '0;
      step_q   <= '0;
      int1_q   <= '0;
      int2_q   <= '0;
      pdm_q    <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      cur_q    <= cur_d;
      target_q <= target_d;
      step_q   <= step_d;
      int1_q   <= int1_d;
      int2_q   <= int2_d;
      pdm_q    <= pdm_d;
      clip_q   <= clip_d;
    end
  end

  assign pdm  = pdm_q;
  assign clip = clip_q;
  assign cur  = cur_q;

endmodule

// File: rtl/mist_audio_sigmadelta.sv
// Stereo PCM to 1-bit PDM output stage: shared handshake, ramp counter and
// dither LFSR feeding two sigma-delta channels.
module mist_audio_sigmadelta
  import mist_audio_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int INTERP_SHIFT = INTERP_SHIFT_DEF,
  parameter bit SIGNED_IN    = 1'b1,
  parameter bit DITHER_EN    = 1'b1
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [DW-1:0]         in_l,
  input  logic [DW-1:0]         in_r,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mute,
  output logic                  out_l,
  output logic                  out_r,
  output logic                  clip_l,
  output logic                  clip_r,
  output logic [DW-1:0]         dbg_cur_l,
  output logic [DW-1:0]         dbg_cur_r,
  output logic [INTERP_SHIFT:0] dbg_ramp_cnt
);

  localparam int RCW = INTERP_SHIFT + 1;
  localparam logic [RCW-1:0] RAMP_LAST = RCW'((1 << INTERP_SHIFT) - 1);

  logic [RCW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic           accept, ramp_active, ramp_last, dither_l, dither_r;

  // Handshake: a pair transfers on a cycle where in_valid && in_ready; in_ready
  // is high only while no ramp is running, and the source holds the pair until then.
  assign in_ready    = (ramp_cnt_q == '0);
  assign accept      = in_valid && in_ready;
  assign ramp_active = (ramp_cnt_q != '0);
  assign ramp_last   = (ramp_cnt_q == RCW'(1));
  assign dither_l    = DITHER_EN ? lfsr_q[0]  : 1'b0;
  assign dither_r    = DITHER_EN ? lfsr_q[15] : 1'b0;

  always_comb begin
    ramp_cnt_d = ramp_cnt_q;
    if (accept)           ramp_cnt_d = RAMP_LAST;
    else if (ramp_active) ramp_cnt_d = ramp_cnt_q - RCW'(1);
    lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ramp_cnt_q <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      ramp_cnt_q <= ramp_cnt_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign dbg_ramp_cnt = ramp_cnt_q;

  mist_sd2_channel #(.DW(DW), .INTERP_SHIFT(INTERP_SHIFT), .SIGNED_IN(SIGNED_IN)) u_left (
    .clk(clk_sys), .rst_n(reset_n), .accept(accept), .ramp_active(ramp_active),
    .ramp_last(ramp_last), .sample(in_l), .mute(mute), .dither(dither_l),
    .pdm(out_l), .clip(clip_l), .cur(dbg_cur_l)
  );

  mist_sd2_channel #(.DW(DW), .INTERP_SHIFT(INTERP_SHIFT), .SIGNED_IN(SIGNED_IN)) u_right (
    .clk(clk_sys), .rst_n(reset_n), .accept(accept), .ramp_active(ramp_active),
    .ramp_last(ramp_last), .sample(in_r), .mute(mute), .dither(dither_r),
    .pdm(out_r), .clip(clip_r), .cur(dbg_cur_r)
  );

endmodule

// File: tb/tb_mist_audio_sigmadelta.sv
// Self-checking bench for mist_audio_sigmadelta: arithmetic reference model,
// per-cycle compare, literal pins and density windows.
module tb_mist_audio_sigmadelta;

  localparam int RAMP = 32;
  localparam int SAT  = 262144;

  logic        clk_sys, reset_n, in_valid, mute;
  logic [15:0] in_l, in_r;
  logic        in_ready, out_l, out_r, clip_l, clip_r;
  logic [15:0] dbg_cur_l, dbg_cur_r;
  logic [5:0]  dbg_ramp_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  mist_audio_sigmadelta dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .in_l(in_l), .in_r(in_r),
    .in_valid(in_valid), .in_ready(in_ready), .mute(mute),
    .out_l(out_l), .out_r(out_r), .clip_l(clip_l), .clip_r(clip_r),
    .dbg_cur_l(dbg_cur_l), .dbg_cur_r(dbg_cur_r), .dbg_ramp_cnt(dbg_ramp_cnt)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=[%0d..%0d]", name, act, lo, hi);
    end
  endtask

  // Reference model: signed sample values, offset binary as value+32768.
  int     m_cur[2], m_target[2], m_base[2], m_step[2], m_j;
  longint m_int1[2], m_int2[2];
  bit     m_out[2], m_clip[2];
  bit [15:0] m_lfsr;

  function automatic int wrap16(input int v);
    int u = v & 32'hFFFF;
    return (u >= 32768) ? u - 65536 : u;
  endfunction

  function automatic longint satv(input longint v);
    if (v > SAT)  return SAT;
    if (v < -SAT) return -SAT;
    return v;
  endfunction

  task automatic model_reset();
    m_j = 0;
    m_lfsr = 16'hACE1;
    for (int c = 0; c < 2; c++) begin
      m_cur[c] = 0; m_target[c] = 0; m_base[c] = 0; m_step[c] = 0;
      m_int1[c] = 0; m_int2[c] = 0; m_out[c] = 0; m_clip[c] = 0;
    end
  endtask

  task automatic model_clock();
    int smp[2];
    int x, fb, d;
    smp[0] = int'($signed(in_l));
    smp[1] = int'($signed(in_r));
    for (int c = 0; c < 2; c++) begin
      x = mute ? 32768 : m_cur[c] + 32768;
      m_clip[c] = (x < 2048) || (x > 65535 - 2048);
      if (x < 2048) x = 2048;
      if (x > 65535 - 2048) x = 65535 - 2048;
      fb = m_out[c] ? 65535 : 0;
      d = (c == 0) ? int'(m_lfsr[0]) : int'(m_lfsr[15]);
      m_int1[c] = satv(m_int1[c] + x - fb + d);
      m_int2[c] = satv(m_int2[c] + m_int1[c] - fb);
      m_out[c] = (m_int2[c] >= 0);
    end
    if (m_j == 0) begin
      if (in_valid) begin
        for (int c = 0; c < 2; c++) begin
          m_target[c] = smp[c];
          m_base[c] = m_cur[c];
          m_step[c] = (smp[c] - m_cur[c]) >>> 5;
        end
        m_j = 1;
      end
    end else begin
      m_j++;
    end
    if (m_j == RAMP) begin
      for (int c = 0; c < 2; c++) m_cur[c] = m_target[c];
      m_j = 0;
    end else if (m_j > 0) begin
      for (int c = 0; c < 2; c++) m_cur[c] = wrap16(m_base[c] + m_j * m_step[c]);
    end
    m_lfsr = {m_lfsr[16-16] ^ m_lfsr[16-14] ^ m_lfsr[16-13] ^ m_lfsr[16-11], m_lfsr[15:1]};
  endtask

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_clock();
  end

  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("out_l", out_l, m_out[0]);
      check("out_r", out_r, m_out[1]);
      check("clip_l", clip_l, m_clip[0]);
      check("clip_r", clip_r, m_clip[1]);
      check("in_ready", in_ready, (m_j == 0));
      check("ramp_cnt", dbg_ramp_cnt, (m_j == 0) ? 0 : RAMP - m_j);
      check("cur_l", int'($signed(dbg_cur_l)), m_cur[0]);
      check("cur_r", int'($signed(dbg_cur_r)), m_cur[1]);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    int t = 0;
    @(negedge clk_sys);
    while (!in_ready && t < 200) begin
      @(negedge clk_sys);
      t++;
    end
    check("send_ready", in_ready, 1);
    in_l = l; in_r = r; in_valid = 1'b1;
    @(negedge clk_sys);
    in_valid = 1'b0;
  endtask

  task automatic measure(input int n, output int ol, output int orr);
    ol = 0; orr = 0;
    repeat (n) begin
      @(negedge clk_sys);
      ol += int'(out_l);
      orr += int'(out_r);
    end
  endtask

  int ol, orr, prev, now;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; mute = 1'b0; in_l = '0; in_r = '0;
    wait_cycles(3);
    check("rst_ready", in_ready, 1);
    check("rst_out_l", out_l, 0);
    check("rst_clip_l", clip_l, 0);
    check("rst_cur_l", dbg_cur_l, 0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    // Midscale with dither: int2 = 32769 then -32764.
    @(negedge clk_sys);
    check("pin_out_l_c1", out_l, 1);
    check("pin_out_r_c1", out_r, 1);
    @(negedge clk_sys);
    check("pin_out_l_c2", out_l, 0);
    check("pin_out_r_c2", out_r, 0);

    // Ramp 0 -> 0x1000: step 128, busy N+1..N+31, done at N+32.
    in_l = 16'h1000; in_r = 16'h0800; in_valid = 1'b1;
    @(negedge clk_sys);
    check("ramp_ready_n1", in_ready, 0);
    check("ramp_cur_n1", dbg_cur_l, 16'h0080);
    in_l = 16'($urandom); in_r = 16'($urandom);
    for (int j = 2; j <= 31; j++) begin
      @(negedge clk_sys);
      check("ramp_busy", in_ready, 0);
      if (j == 31) in_valid = 1'b0;
    end
    @(negedge clk_sys);
    check("ramp_ready_n32", in_ready, 1);
    check("ramp_cur_l_n32", dbg_cur_l, 16'h1000);
    check("ramp_cur_r_n32", dbg_cur_r, 16'h0800);

    // Full scale left: clamped every cycle, ~96.9% ones.
    send_pair(16'h7FFF, 16'h0000);
    wait_cycles(40);
    measure(4096, ol, orr);
    check_range("dens_full_l", ol, (964 * 4096) / 1000, (974 * 4096) / 1000);
    check_range("dens_full_r", orr, (49 * 4096) / 100, (51 * 4096) / 100);
    check("clip_full", clip_l, 1);

    // Asynchronous reset in the middle of a ramp.
    send_pair(16'h7FFF, 16'h0000);
    wait_cycles(5);
    check("pre_rst_ready", in_ready, 0);
    @(posedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_l", out_l, 0);
    check("arst_out_r", out_r, 0);
    check("arst_clip_l", clip_l, 0);
    check("arst_clip_r", clip_r, 0);
    check("arst_ready", in_ready, 1);
    check("arst_cur_l", dbg_cur_l, 0);
    wait_cycles(2);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check("post_rst_ready", in_ready, 1);

    // DC zero.
    send_pair(16'h0000, 16'h0000);
    wait_cycles(40);
    measure(4096, ol, orr);
    check_range("dens_zero_l", ol, (49 * 4096) / 100, (51 * 4096) / 100);
    check_range("dens_zero_r", orr, (49 * 4096) / 100, (51 * 4096) / 100);

    // Mute forces midscale; releasing it gives ~75%.
    mute = 1'b1;
    send_pair(16'h4000, 16'h4000);
    wait_cycles(40);
    measure(4096, ol, orr);
    check_range("dens_mute_l", ol, (49 * 4096) / 100, (51 * 4096) / 100);
    mute = 1'b0;
    wait_cycles(64);
    measure(4096, ol, orr);
    check_range("dens_unmute_l", ol, (74 * 4096) / 100, (76 * 4096) / 100);
    check_range("dens_unmute_r", orr, (74 * 4096) / 100, (76 * 4096) / 100);

    // Negative step 0x7000 -> 0x9000: strictly decreasing, exact at the end.
    send_pair(16'h7000, 16'h7000);
    wait_cycles(40);
    send_pair(16'h9000, 16'h9000);
    prev = 16'sh7000;
    for (int j = 1; j <= 32; j++) begin
      if (j > 1) @(negedge clk_sys);
      now = int'($signed(dbg_cur_l));
      check("neg_decreasing", now < prev, 1);
      prev = now;
    end
    check("neg_end", dbg_cur_l, 16'h9000);

    // Random traffic with mute toggles; the per-cycle compare does the checking.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_sys);
      in_valid = 1'($urandom_range(0, 1));
      in_l = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000)
                                         : 16'($urandom);
      in_r = 16'($urandom);
      if ($urandom_range(0, 15) == 0) mute = ~mute;
    end
    in_valid = 1'b0;
    mute = 1'b0;
    wait_cycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
